led_scan_scheduler: RTL

//  Sequences the row-scan of the HUB75-style LED matrix: requests row shifts from the display PHY,

---
 rtl/led_scan_scheduler.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/led_scan_scheduler.sv
// HUB75 row-scan sequencer: shifts the next (row, plane) while the current one is shown
// with binary-coded-modulation weighting, then blanks, latches and re-lights the panel.
module led_scan_scheduler #(
    parameter int NUM_ROWS       = 32,
    parameter int BIT_PLANES     = 4,
    parameter int BASE_ON_CYCLES = 64,
    parameter int BLANK_CYCLES   = 4,
    localparam int SCAN_ROWS = NUM_ROWS / 2,
    localparam int ADDR_W    = (SCAN_ROWS > 1) ? $clog2(SCAN_ROWS) : 1,
    localparam int PLANE_W   = (BIT_PLANES > 1) ? $clog2(BIT_PLANES) : 1
) (
    input  logic               clk_in,
    input  logic               n_reset_in,
    input  logic               enable_in,
    input  logic               phy_ready_in,
    output logic               phy_enable_out,
    output logic [ADDR_W-1:0]  row_addr_out,
    output logic [PLANE_W-1:0] plane_out,
    output logic               frame_start_out,
    output logic [ADDR_W-1:0]  addr_out,
    output logic               latch_enable_out,
    output logic               output_enable_out
);

    localparam int CNT_W = $clog2((BASE_ON_CYCLES << (BIT_PLANES - 1)) + 1);
    localparam int BLK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

    localparam logic [ADDR_W-1:0]  ROW_LAST   = ADDR_W'(SCAN_ROWS - 1);
    localparam logic [PLANE_W-1:0] PLANE_LAST = PLANE_W'(BIT_PLANES - 1);
    localparam logic [CNT_W-1:0]   BASE_CNT   = CNT_W'(BASE_ON_CYCLES);
    localparam logic [BLK_W-1:0]   BLANK_LAST = BLK_W'(BLANK_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_BLANK,
        S_LATCH,
        S_DISPLAY
    } state_t;

    state_t             state_q;
    logic [ADDR_W-1:0]  ptr_row_q;
    logic [PLANE_W-1:0] ptr_plane_q;
    logic [CNT_W-1:0]   on_cnt_q;
    logic [BLK_W-1:0]   blank_cnt_q;
    logic               shift_busy_q;
    logic [1:0]         shift_ign_q;
    logic               issue_pend_q;
    logic               stop_q;

    logic               phy_en_q;
    logic [ADDR_W-1:0]  row_q;
    logic [PLANE_W-1:0] plane_q;
    logic               frame_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               le_q;
    logic               oe_q;

    logic shift_pending;
    logic issue_now;
    logic at_origin;

    // The PHY needs a cycle to drop ready after a request, so the pulse cycle and
    // the one after it carry stale ready and are skipped.
    always_comb begin
        shift_pending = shift_busy_q && !((shift_ign_q == 2'd0) && phy_ready_in);
        at_origin     = (ptr_row_q == '0) && (ptr_plane_q == '0);
        issue_now     = 1'b0;
        if (state_q == S_IDLE) begin
            issue_now = enable_in && phy_ready_in;
        end else if (state_q == S_DISPLAY) begin
            issue_now = issue_pend_q && enable_in && phy_ready_in;
        end
    end

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            state_q      <= S_IDLE;
            ptr_row_q    <= '0;
            ptr_plane_q  <= '0;
            on_cnt_q     <= '0;
            blank_cnt_q  <= '0;
            shift_busy_q <= 1'b0;
            shift_ign_q  <= 2'd0;
            issue_pend_q <= 1'b0;
            stop_q       <= 1'b0;
            phy_en_q     <= 1'b0;
            row_q        <= '0;
            plane_q      <= '0;
            frame_q      <= 1'b0;
            addr_q       <= '0;
            le_q         <= 1'b0;
            oe_q         <= 1'b0;
        end else begin
            phy_en_q <= 1'b0;
            frame_q  <= 1'b0;
            le_q     <= 1'b0;

            if (issue_now) begin
                shift_busy_q <= 1'b1;
                shift_ign_q  <= 2'd2;
                phy_en_q     <= 1'b1;
                row_q        <= ptr_row_q;
                plane_q      <= ptr_plane_q;
                frame_q      <= at_origin;
            end else if (shift_busy_q) begin
                if (shift_ign_q != 2'd0) begin
                    shift_ign_q <= shift_ign_q - 2'd1;
                end else if (phy_ready_in) begin
                    shift_busy_q <= 1'b0;
                end
            end

            case (state_q)
                S_IDLE: begin
                    oe_q <= 1'b0;
                    if (issue_now) begin
                        state_q <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (!shift_pending) begin
                        blank_cnt_q <= BLANK_LAST;
                        state_q     <= S_BLANK;
                    end
                end
                S_BLANK: begin
                    if (blank_cnt_q == '0) begin
                        state_q  <= S_LATCH;
                        le_q     <= 1'b1;
                        addr_q   <= ptr_row_q;
                        on_cnt_q <= BASE_CNT << ptr_plane_q;
                        stop_q   <= 1'b0;
                        if (ptr_plane_q == PLANE_LAST) begin
                            ptr_plane_q <= '0;
                            ptr_row_q   <= (ptr_row_q == ROW_LAST) ? '0 : ptr_row_q + ADDR_W'(1);
                        end else begin
                            ptr_plane_q <= ptr_plane_q + PLANE_W'(1);
                        end
                    end else begin
                        blank_cnt_q <= blank_cnt_q - BLK_W'(1);
                    end
                end
                S_LATCH: begin
                    state_q      <= S_DISPLAY;
                    oe_q         <= 1'b1;
                    issue_pend_q <= 1'b1;
                end
                S_DISPLAY: begin
                    // OE drops the moment the weight is spent, independent of the PHY.
                    if (on_cnt_q != '0) begin
                        on_cnt_q <= on_cnt_q - CNT_W'(1);
                        oe_q     <= (on_cnt_q != CNT_W'(1));
                    end
                    if (issue_pend_q && !enable_in) begin
                        issue_pend_q <= 1'b0;
                        stop_q       <= 1'b1;
                    end else if (issue_now) begin
                        issue_pend_q <= 1'b0;
                    end
                    if ((on_cnt_q == '0) && !issue_pend_q && !shift_pending) begin
                        if (stop_q || !enable_in) begin
                            state_q     <= S_IDLE;
                            ptr_row_q   <= '0;
                            ptr_plane_q <= '0;
                        end else begin
                            blank_cnt_q <= BLANK_LAST;
                            state_q     <= S_BLANK;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    oe_q    <= 1'b0;
                end
            endcase
        end
    end

    assign phy_enable_out    = phy_en_q;
    assign row_addr_out      = row_q;
    assign plane_out         = plane_q;
    assign frame_start_out   = frame_q;
    assign addr_out          = addr_q;
    assign latch_enable_out  = le_q;
    assign output_enable_out = oe_q;

endmodule
